// File: rtl/btb_update_ctrl.sv
// BTB write sequencer: queues EX-stage branch resolutions into the BTB update port
// and runs a full invalidate sweep after reset or fence, gating predictions meanwhile.
module btb_update_ctrl #(
  parameter int BTB_ENTRIES  = 128,
  parameter int INDEX_WIDTH  = $clog2(BTB_ENTRIES),
  parameter int TARGET_WIDTH = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    resValid,
  input  logic                    resBranch,
  input  logic                    resTaken,
  input  logic [31:0]             resPc,
  input  logic [TARGET_WIDTH-1:0] resTarget,
  input  logic                    fenceReq,
  input  logic                    btbUpdReady,
  output logic                    btbUpdValid,
  output logic                    btbUpdTaken,
  output logic [31:0]             btbUpdPc,
  output logic [TARGET_WIDTH-1:0] btbUpdTarget,
  output logic                    btbInvValid,
  output logic [INDEX_WIDTH-1:0]  btbInvIndex,
  output logic                    predEnable,
  output logic                    sweepDone,
  output logic [7:0]              dropCnt,
  output logic [1:0]              state_dbg
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 1 + 32 + TARGET_WIDTH;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] S_INIT  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]             state;
  logic [INDEX_WIDTH-1:0] sweep_idx;
  logic                   sweep_done_q;
  logic [ENT_W-1:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W:0]         count;
  logic [7:0]             drop_q;

  logic running;
  logic sweeping;
  logic fifo_empty;
  logic fifo_full;
  logic push_req;
  logic push;
  logic pop;
  logic drop;
  logic sweep_last;
  logic upd_valid_int;
  logic [ENT_W-1:0] head;

  // Update handshake: btbUpdValid presents the FIFO head; it transfers (and pops)
  // in any cycle where btbUpdValid and btbUpdReady are both 1. Valid never waits on ready.
  assign running       = (state == S_RUN);
  assign sweeping      = (state == S_SWEEP);
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == FULL_COUNT);
  assign upd_valid_int = running && !fifo_empty;
  assign pop           = upd_valid_int && btbUpdReady;
  assign push_req      = running && resValid && resBranch;
  assign push          = push_req && (!fifo_full || pop);
  assign drop          = push_req && fifo_full && !pop;
  assign sweep_last    = (sweep_idx == '1);
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= S_INIT;
      sweep_idx    <= '0;
      sweep_done_q <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      drop_q       <= '0;
    end else begin
      sweep_done_q <= 1'b0;
      case (state)
        S_INIT: begin
          state     <= S_SWEEP;
          sweep_idx <= '0;
        end
        S_SWEEP: begin
          if (fenceReq) begin
            sweep_idx <= '0;
          end else if (sweep_last) begin
            state        <= S_RUN;
            sweep_done_q <= 1'b1;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        S_RUN: begin
          if (fenceReq) begin
            // Fence discards everything queued, including this cycle's push and pop.
            state     <= S_SWEEP;
            sweep_idx <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
          end else begin
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
              2'b10:   count <= count + 1'b1;
              2'b01:   count <= count - 1'b1;
              default: count <= count;
            endcase
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 1'b1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && push && !fenceReq) mem[wr_ptr] <= {resTaken, resPc, resTarget};
  end

  // Outputs are forced low while reset is held, even before the first reset edge.
  always_comb begin
    btbUpdValid  = rst && upd_valid_int;
    btbUpdTaken  = 1'b0;
    btbUpdPc     = '0;
    btbUpdTarget = '0;
    if (rst && upd_valid_int) begin
      btbUpdTaken  = head[ENT_W-1];
      btbUpdPc     = head[TARGET_WIDTH +: 32];
      btbUpdTarget = head[TARGET_WIDTH-1:0];
    end
    btbInvValid = rst && sweeping;
    btbInvIndex = (rst && sweeping) ? sweep_idx : '0;
    predEnable  = rst && running;
    sweepDone   = rst && sweep_done_q;
    dropCnt     = rst ? drop_q : 8'd0;
    state_dbg   = rst ? state : S_INIT;
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: directed vector table, hand-written sweep/fence/reset
// sequences, and randomized traffic checked every cycle against a queue-based model.
module tb_btb_update_ctrl;
  localparam int ENTRIES = 128;
  localparam int IW      = 7;
  localparam int TW      = 32;
  localparam int DEPTH   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          resValid = 1'b0, resBranch = 1'b0, resTaken = 1'b0;
  logic [31:0]   resPc = '0;
  logic [TW-1:0] resTarget = '0;
  logic          fenceReq = 1'b0, btbUpdReady = 1'b0;
  logic          btbUpdValid, btbUpdTaken;
  logic [31:0]   btbUpdPc;
  logic [TW-1:0] btbUpdTarget;
  logic          btbInvValid;
  logic [IW-1:0] btbInvIndex;
  logic          predEnable, sweepDone;
  logic [7:0]    dropCnt;
  logic [1:0]    state_dbg;

  btb_update_ctrl #(.BTB_ENTRIES(ENTRIES), .TARGET_WIDTH(TW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .resValid(resValid), .resBranch(resBranch), .resTaken(resTaken),
    .resPc(resPc), .resTarget(resTarget), .fenceReq(fenceReq), .btbUpdReady(btbUpdReady),
    .btbUpdValid(btbUpdValid), .btbUpdTaken(btbUpdTaken), .btbUpdPc(btbUpdPc),
    .btbUpdTarget(btbUpdTarget), .btbInvValid(btbInvValid), .btbInvIndex(btbInvIndex),
    .predEnable(predEnable), .sweepDone(sweepDone), .dropCnt(dropCnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a phase flag pair, a sweep position and a plain queue of resolutions.
  typedef struct packed {
    logic          taken;
    logic [31:0]   pc;
    logic [TW-1:0] target;
  } ent_t;
  ent_t exp_q[$];
  bit   m_run = 1'b0, m_sweep = 1'b0, m_done = 1'b0;
  int   m_idx = 0, m_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit popped;
    if (!rst) begin
      exp_q.delete();
      m_run = 0; m_sweep = 0; m_idx = 0; m_done = 0; m_drop = 0;
      return;
    end
    m_done = 0;
    if (!m_run && !m_sweep) begin
      m_sweep = 1; m_idx = 0;
    end else if (m_sweep) begin
      if (fenceReq) m_idx = 0;
      else if (m_idx == ENTRIES - 1) begin m_sweep = 0; m_run = 1; m_done = 1; end
      else m_idx++;
    end else if (fenceReq) begin
      exp_q.delete();
      m_run = 0; m_sweep = 1; m_idx = 0;
    end else begin
      popped = (exp_q.size() > 0) && btbUpdReady;
      if (popped) void'(exp_q.pop_front());
      if (resValid && resBranch) begin
        if (exp_q.size() < DEPTH) exp_q.push_back('{resTaken, resPc, resTarget});
        else if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic check_model();
    bit   ok = 1;
    bit   ev;
    ent_t eh = '0;
    ev = m_run && exp_q.size() > 0;
    if (ev) eh = exp_q[0];
    if (btbUpdValid !== ev) ok = 0;
    if ((ev || !rst) && {btbUpdTaken, btbUpdPc, btbUpdTarget} !== eh) ok = 0;
    if (btbInvValid !== m_sweep) ok = 0;
    if ((m_sweep || !rst) && btbInvIndex !== IW'(m_idx)) ok = 0;
    if (predEnable !== m_run) ok = 0;
    if (sweepDone !== m_done) ok = 0;
    if (dropCnt !== 8'(m_drop)) ok = 0;
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL model t=%0t: got uv=%b pc=%h tg=%h iv=%b ix=%0d pe=%b sd=%b dc=%0d expected uv=%b pc=%h tg=%h iv=%b ix=%0d pe=%b sd=%b dc=%0d",
               $time, btbUpdValid, btbUpdPc, btbUpdTarget, btbInvValid, btbInvIndex, predEnable,
               sweepDone, dropCnt, ev, eh.pc, eh.target, m_sweep, m_idx, m_run, m_done, m_drop);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    resValid = 0; resBranch = 0; resTaken = 0; resPc = '0; resTarget = '0; fenceReq = 0;
  endtask

  task automatic drive_res(input logic br, input logic tk, input logic [31:0] pc, input logic [31:0] tg);
    resValid = 1; resBranch = br; resTaken = tk; resPc = pc; resTarget = tg;
  endtask

  task automatic rand_res();
    resValid  = ($urandom_range(0, 1) == 1);
    resBranch = ($urandom_range(0, 3) != 0);
    resTaken  = $urandom_range(0, 1);
    resPc     = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
    resTarget = $urandom;
  endtask

  // Called right after reset is released; walks the full sweep into RUN.
  task automatic run_sweep_check(input string tag);
    bit saw_upd = 0;
    for (int k = 1; k <= ENTRIES + 2; k++) begin
      tick();
      if (k <= ENTRIES && btbUpdValid) saw_upd = 1;
      if (k == 1) begin
        check({tag, "_first_idx"}, btbInvIndex, 0);
        check({tag, "_first_inv"}, btbInvValid, 1);
      end
      if (k == 64) check({tag, "_mid_idx"}, btbInvIndex, 63);
      if (k == ENTRIES) begin
        check({tag, "_last_idx"}, btbInvIndex, ENTRIES - 1);
        check({tag, "_last_pred"}, predEnable, 0);
        check({tag, "_last_done"}, sweepDone, 0);
      end
      if (k == ENTRIES + 1) begin
        check({tag, "_done_pulse"}, sweepDone, 1);
        check({tag, "_pred_on"}, predEnable, 1);
        check({tag, "_inv_off"}, btbInvValid, 0);
      end
      if (k == ENTRIES + 2) check({tag, "_done_single"}, sweepDone, 0);
    end
    check({tag, "_no_upd_in_sweep"}, saw_upd, 0);
  endtask

  typedef struct {
    logic v, b, t;
    logic [31:0] pc, tg;
    logic rdy;
    logic ev, et;
    logic [31:0] epc, etg;
    logic [7:0] ed;
  } vec_t;

  function automatic vec_t mk(input logic v, input logic b, input logic t, input logic [31:0] pc,
                              input logic [31:0] tg, input logic rdy, input logic ev, input logic et,
                              input logic [31:0] epc, input logic [31:0] etg, input logic [7:0] ed);
    vec_t r;
    r.v = v; r.b = b; r.t = t; r.pc = pc; r.tg = tg; r.rdy = rdy;
    r.ev = ev; r.et = et; r.epc = epc; r.etg = etg; r.ed = ed;
    return r;
  endfunction

  vec_t tbl[19];

  initial begin
    bit seen_flushed;
    // Ordered drain under backpressure, overflow, full-plus-pop, then non-branch filtering.
    tbl[0]  = mk(1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 8'd0);
    tbl[1]  = mk(1'b1, 1'b1, 1'b1, 32'h104, 32'h300, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 8'd0);
    tbl[2]  = mk(1'b1, 1'b1, 1'b1, 32'h108, 32'h400, 1'b0, 1'b1, 1'b1, 32'h100, 32'h200, 8'd0);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 1'b1, 32'h104, 32'h300, 8'd0);
    tbl[4]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b1, 1'b1, 32'h108, 32'h400, 8'd0);
    tbl[5]  = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,   1'b1, 1'b0, 1'b0, 32'h0,   32'h0,   8'd0);
    tbl[6]  = mk(1'b1, 1'b1, 1'b0, 32'h10,  32'h1010, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd0);
    tbl[7]  = mk(1'b1, 1'b1, 1'b1, 32'h14,  32'h1014, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd0);
    tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h18,  32'h1018, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd0);
    tbl[9]  = mk(1'b1, 1'b1, 1'b1, 32'h1C,  32'h101C, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd0);
    tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h20,  32'h1020, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd1);
    tbl[11] = mk(1'b1, 1'b1, 1'b1, 32'h24,  32'h1024, 1'b0, 1'b1, 1'b0, 32'h10, 32'h1010, 8'd2);
    tbl[12] = mk(1'b1, 1'b1, 1'b0, 32'h28,  32'h1028, 1'b1, 1'b1, 1'b1, 32'h14, 32'h1014, 8'd2);
    tbl[13] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 1'b0, 32'h18, 32'h1018, 8'd2);
    tbl[14] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 1'b1, 32'h1C, 32'h101C, 8'd2);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b1, 1'b0, 32'h28, 32'h1028, 8'd2);
    tbl[16] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b1, 1'b0, 1'b0, 32'h0,  32'h0,    8'd2);
    tbl[17] = mk(1'b1, 1'b0, 1'b1, 32'h30,  32'h1030, 1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    8'd2);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 32'h0,   32'h0,    1'b0, 1'b0, 1'b0, 32'h0,  32'h0,    8'd2);

    // Clock/reset
    idle();
    btbUpdReady = 0;
    rst = 0;
    repeat (3) tick();
    check("reset_upd_valid", btbUpdValid, 0);
    check("reset_inv_valid", btbInvValid, 0);
    check("reset_pred", predEnable, 0);
    check("reset_drop", dropCnt, 0);
    rst = 1;
    run_sweep_check("init_sweep");

    for (int i = 0; i < 19; i++) begin
      resValid = tbl[i].v; resBranch = tbl[i].b; resTaken = tbl[i].t;
      resPc = tbl[i].pc; resTarget = tbl[i].tg; btbUpdReady = tbl[i].rdy;
      tick();
      idle();
      n_checks++;
      if (btbUpdValid !== tbl[i].ev || dropCnt !== tbl[i].ed ||
          (tbl[i].ev && {btbUpdTaken, btbUpdPc, btbUpdTarget} !== {tbl[i].et, tbl[i].epc, tbl[i].etg})) begin
        n_fail++;
        $display("FAIL vec%0d: got v=%b t=%b pc=%h tg=%h drop=%0d expected v=%b t=%b pc=%h tg=%h drop=%0d",
                 i, btbUpdValid, btbUpdTaken, btbUpdPc, btbUpdTarget, dropCnt,
                 tbl[i].ev, tbl[i].et, tbl[i].epc, tbl[i].etg, tbl[i].ed);
      end
    end

    // Fence mid-drain with a simultaneous resolution and pop.
    btbUpdReady = 0;
    drive_res(1, 1, 32'h500, 32'h600); tick();
    drive_res(1, 0, 32'h504, 32'h604); tick();
    idle(); tick();
    check("fence_pre_head", btbUpdPc, 32'h500);
    fenceReq = 1; drive_res(1, 1, 32'h508, 32'h608); btbUpdReady = 1;
    tick();
    idle();
    check("fence_upd_off", btbUpdValid, 0);
    check("fence_pred_off", predEnable, 0);
    check("fence_sweep_idx0", {btbInvValid, btbInvIndex}, {1'b1, 7'd0});
    seen_flushed = 0;
    for (int k = 1; k <= 50; k++) begin
      rand_res(); tick();
      if (btbUpdValid) seen_flushed = 1;
    end
    check("sweep_idx50", btbInvIndex, 50);
    rand_res(); fenceReq = 1; tick(); fenceReq = 0;
    check("sweep_restart_idx", btbInvIndex, 0);
    for (int k = 1; k <= ENTRIES; k++) begin
      rand_res(); tick();
      if (btbUpdValid) seen_flushed = 1;
      if (k == ENTRIES - 1) check("restart_pre_done", sweepDone, 0);
      if (k == ENTRIES) check("restart_done", sweepDone, 1);
    end
    idle(); tick();
    check("flushed_never_seen", seen_flushed, 0);
    check("sweep_inputs_not_queued", btbUpdValid, 0);
    check("sweep_drop_unchanged", dropCnt, 2);

    // Randomized traffic with occasional fences.
    for (int k = 0; k < 1500; k++) begin
      rand_res();
      btbUpdReady = ($urandom_range(0, 9) < 6);
      fenceReq = ($urandom_range(0, 299) == 0);
      tick();
    end
    idle();

    // Saturate the drop counter with a stalled BTB port.
    btbUpdReady = 0;
    for (int k = 0; k < 450; k++) begin
      drive_res(1, $urandom_range(0, 1), $urandom, $urandom);
      tick();
    end
    idle();
    check("drop_saturated", dropCnt, 255);
    tick();
    check("drop_held", dropCnt, 255);

    // Reset mid-operation with a full FIFO and dropCnt=3.
    rst = 0; tick();
    check("reset2_drop_cleared", dropCnt, 0);
    rst = 1;
    run_sweep_check("reset2_sweep");
    for (int k = 0; k < DEPTH + 3; k++) begin
      drive_res(1, 1, 32'h700 + 32'(4 * k), 32'h800 + 32'(k));
      tick();
    end
    idle();
    check("prefill_drop3", dropCnt, 3);
    check("prefill_head", btbUpdPc, 32'h700);
    rst = 0; tick();
    check("midrst_outputs", {btbUpdValid, btbUpdTaken, btbUpdPc, btbUpdTarget, btbInvValid, btbInvIndex,
                             predEnable, sweepDone}, '0);
    check("midrst_drop", dropCnt, 0);
    rst = 1;
    run_sweep_check("midrst_sweep");
    btbUpdReady = 1; tick();
    check("midrst_fifo_empty", btbUpdValid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
# btb_update_ctrl

Sequences all writes into the branch target buffer and gates its predictions. It holds EX-stage branch resolutions in a small FIFO and drains them into the BTB update port when that shared port is free. After reset, and on every fence request, it runs a full invalidate sweep and holds predictions off until the sweep completes. It sits between the EX stage, the fetch-stage prediction consumer and the BTB.

## Interface
- BTB_ENTRIES, 128, BTB entry count (power of two)
- INDEX_WIDTH, $clog2(BTB_ENTRIES), sweep index width
- TARGET_WIDTH, 32, branch target width
- FIFO_DEPTH, 4, resolution FIFO entries (power of two, ≥2)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-low; clock clk
- resValid  in  1  EX resolution present this cycle
- resBranch  in  1  resolution is a control-transfer instruction
- resTaken  in  1  branch was taken
- resPc  in  32  PC of the resolved instruction
- resTarget  in  TARGET_WIDTH  resolved target
- fenceReq  in  1  single-cycle request to invalidate the whole BTB
- btbUpdReady  in  1  BTB update port free this cycle
- btbUpdValid  out  1  update presented to the BTB (drives exBranch)
- btbUpdTaken  out  1  → exTaken
- btbUpdPc  out  32  → exPc
- btbUpdTarget  out  TARGET_WIDTH  → exTarget
- btbInvValid  out  1  write an all-zero entry at btbInvIndex
- btbInvIndex  out  INDEX_WIDTH  entry being invalidated
- predEnable  out  1  fetch may use fetchHit; 0 means ignore
- sweepDone  out  1  one-cycle pulse when a sweep finishes
- dropCnt  out  8  saturating count of resolutions lost to a full FIFO

## Operation
- FSM states: INIT, SWEEP, RUN. Reset state is INIT.
- INIT → SWEEP unconditionally; sweep counter set to 0.
- SWEEP:
  - btbInvValid=1, btbInvIndex=counter; counter increments every cycle.
  - At counter = BTB_ENTRIES-1 → RUN next cycle.
  - Resolutions are ignored: not enqueued, not counted.
  - fenceReq restarts the counter at 0.
- RUN:
  - predEnable=1.
  - Resolutions with resValid&resBranch are enqueued as {taken, pc, target}. Non-branches are ignored.
  - FIFO head drives btbUpd*, with btbUpdValid = !empty. The head pops when btbUpdValid&btbUpdReady.
  - fenceReq flushes the FIFO, including any same-cycle resolution and any same-cycle pop, and moves to SWEEP with counter 0.
- In RUN, btbUpdValid and btbInvValid are never both 1.
- FIFO full:
  - An enqueue in a cycle that also pops is accepted, and occupancy is unchanged.
  - An enqueue with no pop is dropped; dropCnt increments, saturating at 255.
- dropCnt is cleared only by reset, not by a fence.
- FIFO order is strict: updates reach the BTB in resolution order.

## Timing
- While rst=0 (any cycle, including mid-sweep or mid-drain):
  - State goes to INIT and the FIFO empties.
  - All outputs are 0 and dropCnt=0.
- Take cycle 0 as the first clock edge with rst=1.
  - Edge 0: INIT→SWEEP.
  - Cycles 1..BTB_ENTRIES: btbInvIndex = 0..BTB_ENTRIES-1.
  - Cycle BTB_ENTRIES+1: RUN, predEnable=1, sweepDone=1 for this cycle only.
- Fence sampled at edge N in RUN:
  - From cycle N+1: predEnable=0, FIFO empty, and the sweep proceeds as above.
  - sweepDone and predEnable=1 come BTB_ENTRIES cycles later.
- Resolution to BTB latency: an enqueue at edge N appears on btbUpd* in cycle N+1 at the earliest. There is no bypass.
- Throughput: 1 enqueue and 1 pop per cycle.
- All outputs are decoded from registered state. None depends combinationally on res* or fenceReq.

## Test plan
- Reset sweep:
  - Stimulus: release rst.
  - Response: btbInvIndex steps 0..127 over cycles 1..128. sweepDone pulses and predEnable rises in cycle 129. No btbUpdValid before cycle 129.
- Ordered drain under backpressure:
  - Stimulus: in RUN with btbUpdReady=0, enqueue pc 0x100/0x104/0x108 (taken, targets 0x200/0x300/0x400). Then raise ready.
  - Response: three updates appear in that order on consecutive cycles. btbUpdValid drops after the third.
- Overflow:
  - Stimulus: ready=0, six branch resolutions with FIFO_DEPTH=4.
  - Response: dropCnt=2, the first four are retained, and they drain in order.
  - Full plus pop: with the FIFO full and ready=1, an enqueue is accepted and dropCnt is unchanged.
- Fence mid-drain:
  - Stimulus: two entries queued, then fenceReq with a simultaneous resolution.
  - Response: the FIFO is empty next cycle, predEnable=0, and the sweep starts at index 0. Neither queued entry ever reaches btbUpd*.
- Filtering and sweep-time inputs:
  - Stimulus: resBranch=0 resolutions in RUN; branch resolutions during SWEEP; fenceReq at sweep index 50.
  - Response: nothing enqueued and dropCnt unchanged. The sweep restarts at 0, and sweepDone comes 128 cycles after the restart.
- Reset mid-operation:
  - Stimulus: rst low during RUN with a full FIFO and dropCnt=3.
  - Response: all outputs 0 and dropCnt=0. The full sweep repeats after release.
